// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use scoreboard.
package fwd_pkg;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // Per-slot control flags. Destination and source addresses are kept
  // beside the flags because their width is a module parameter.
  typedef struct packed {
    logic valid;
    logic wb;
    logic load;
  } slot_flags_t;

  // Width of one forward select field: it encodes 0 (register file)
  // and 1..depth (post-EX stage).
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one source address against a vector of producer slots.
// Position 0 is the youngest producer, so the lowest matching index wins.
module fwd_match #(
  parameter int ADDR_W = 5,
  parameter int N      = 2,
  parameter int IDX_W  = 2
) (
  input  logic                en_i,
  input  logic [ADDR_W-1:0]   src_i,
  input  logic [N-1:0]        live_i,
  input  logic [N-1:0]        load_i,
  input  logic [N*ADDR_W-1:0] dst_i,
  output logic                hit_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                load_o
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    load_o = 1'b0;
    if (en_i && (src_i != '0)) begin
      for (int p = N - 1; p >= 0; p--) begin
        if (live_i[p] && (dst_i[p*ADDR_W +: ADDR_W] == src_i)) begin
          hit_o  = 1'b1;
          idx_o  = IDX_W'(p);
          load_o = load_i[p];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding and load-use hazard unit with a private scoreboard of the
// EX slot plus DEPTH post-EX stages.
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              hold_i,
  input  logic                              flush_i,
  input  logic                              id_valid_i,
  input  logic [NUM_SRC*ADDR_W-1:0]         id_src_addr_i,
  input  logic [ADDR_W-1:0]                 id_dst_addr_i,
  input  logic                              id_wb_i,
  input  logic                              id_load_i,
  output logic [NUM_SRC*sel_w(DEPTH)-1:0]   fwd_sel_o,
  output logic                              stall_o,
  output logic [CNT_W-1:0]                  stall_cnt_o
);

  localparam int SEL_W = sel_w(DEPTH);
  localparam int IDX_W = SEL_W;

  slot_flags_t                 ex_flags_q, ex_flags_d;
  logic [ADDR_W-1:0]           ex_dst_q, ex_dst_d;
  logic [NUM_SRC*ADDR_W-1:0]   ex_src_q, ex_src_d;
  slot_flags_t [DEPTH-1:0]     st_flags_q, st_flags_d;
  logic [DEPTH*ADDR_W-1:0]     st_dst_q, st_dst_d;
  logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0]            st_live, st_load;
  logic [DEPTH-1:0]            pos_live, pos_load;
  logic [DEPTH*ADDR_W-1:0]     pos_dst;
  logic [NUM_SRC-1:0]          ex_hit, ex_mload, id_hit, id_mload, id_hazard;
  logic [NUM_SRC*IDX_W-1:0]    ex_idx, id_idx;
  logic                        stall;

  // Liveness of the post-EX stages (forwarding sources for EX).
  always_comb begin
    st_live = '0;
    st_load = '0;
    for (int k = 0; k < DEPTH; k++) begin
      st_live[k] = st_flags_q[k].valid && st_flags_q[k].wb &&
                   (st_dst_q[k*ADDR_W +: ADDR_W] != '0);
      st_load[k] = st_flags_q[k].load;
    end
  end

  // Producers visible to ID: EX slot at position 0, then stages 1..DEPTH-1.
  always_comb begin
    pos_live = '0;
    pos_load = '0;
    pos_dst  = '0;
    pos_live[0] = ex_flags_q.valid && ex_flags_q.wb && (ex_dst_q != '0);
    pos_load[0] = ex_flags_q.load;
    pos_dst[0 +: ADDR_W] = ex_dst_q;
    for (int p = 1; p < DEPTH; p++) begin
      pos_live[p] = st_flags_q[p-1].valid && st_flags_q[p-1].wb &&
                    (st_dst_q[(p-1)*ADDR_W +: ADDR_W] != '0);
      pos_load[p] = st_flags_q[p-1].load;
      pos_dst[p*ADDR_W +: ADDR_W] = st_dst_q[(p-1)*ADDR_W +: ADDR_W];
    end
  end

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_op
    fwd_match #(.ADDR_W(ADDR_W), .N(DEPTH), .IDX_W(IDX_W)) u_ex_match (
      .en_i   (ex_flags_q.valid),
      .src_i  (ex_src_q[j*ADDR_W +: ADDR_W]),
      .live_i (st_live),
      .load_i (st_load),
      .dst_i  (st_dst_q),
      .hit_o  (ex_hit[j]),
      .idx_o  (ex_idx[j*IDX_W +: IDX_W]),
      .load_o (ex_mload[j])
    );

    fwd_match #(.ADDR_W(ADDR_W), .N(DEPTH), .IDX_W(IDX_W)) u_id_match (
      .en_i   (id_valid_i),
      .src_i  (id_src_addr_i[j*ADDR_W +: ADDR_W]),
      .live_i (pos_live),
      .load_i (pos_load),
      .dst_i  (pos_dst),
      .hit_o  (id_hit[j]),
      .idx_o  (id_idx[j*IDX_W +: IDX_W]),
      .load_o (id_mload[j])
    );
  end

  // Forward selects for EX and the load-use stall decision for ID.
  always_comb begin
    fwd_sel_o = '0;
    id_hazard = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      fwd_sel_o[j*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
      // A load matched before its data is ready falls back to the register file.
      if (ex_hit[j] && (!ex_mload[j] ||
          (int'(ex_idx[j*IDX_W +: IDX_W]) + 1 >= LOAD_READY)))
        fwd_sel_o[j*SEL_W +: SEL_W] = SEL_W'(int'(ex_idx[j*IDX_W +: IDX_W]) + 1);
      id_hazard[j] = id_hit[j] && id_mload[j] &&
                     (int'(id_idx[j*IDX_W +: IDX_W]) + 1 < LOAD_READY);
    end
    stall = (|id_hazard) && !flush_i && !hold_i;
  end

  // Scoreboard advance and saturating stall counter.
  always_comb begin
    ex_flags_d  = ex_flags_q;
    ex_dst_d    = ex_dst_q;
    ex_src_d    = ex_src_q;
    st_flags_d  = st_flags_q;
    st_dst_d    = st_dst_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold_i) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        st_flags_d[k] = st_flags_q[k-1];
        st_dst_d[k*ADDR_W +: ADDR_W] = st_dst_q[(k-1)*ADDR_W +: ADDR_W];
      end
      st_flags_d[0] = ex_flags_q;
      st_dst_d[0 +: ADDR_W] = ex_dst_q;
      if (id_valid_i && !stall && !flush_i) begin
        ex_flags_d.valid = 1'b1;
        ex_flags_d.wb    = id_wb_i;
        ex_flags_d.load  = id_load_i;
        ex_dst_d         = id_dst_addr_i;
        ex_src_d         = id_src_addr_i;
      end else begin
        ex_flags_d = '0;
        ex_dst_d   = '0;
        ex_src_d   = '0;
      end
      if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset clears every slot and the counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_flags_q  <= '0;
      ex_dst_q    <= '0;
      ex_src_q    <= '0;
      st_flags_q  <= '0;
      st_dst_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_flags_q  <= ex_flags_d;
      ex_dst_q    <= ex_dst_d;
      ex_src_q    <= ex_src_d;
      st_flags_q  <= st_flags_d;
      st_dst_q    <= st_dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o     = stall;
  assign stall_cnt_o = stall_cnt_q;

endmodule
